lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Attempt-limited, reprogrammable combination-lock controller between the Enter pulse generator and the board LEDs. Collects CodeLength digits on Enter pulses, compares them against a stored code, drives timed Open/Fail indication, and enforces a lockout after MaxAttempts consecutive failures. While open, the user may program a new code.

## Interface
- ClockFreq, 50000000: clock rate in Hz; informational only, used to size the cycle defaults.
- CodeLength, 4: digits per code, from 1 to 4.
- DefaultCode, 16'h1234: reset code. The first digit is [15:12]; the used digits are the upper CodeLength nibbles.
- MaxAttempts, 3: consecutive failures that trigger lockout, from 1 to 15.
- OpenCycles, ClockFreq*5: cycles that Open stays asserted.
- LockoutCycles, ClockFreq*30: cycles spent in lockout.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Enter  in  1  single-cycle pulse; the block assumes it has already been converted from a level to a pulse.
- Digit  in  4  digit sampled on an Enter pulse; any nibble value is legal.
- Program  in  1  level input that requests code programming.
- State  out  3  current state encoding.
- Open  out  1  lock open.
- Fail  out  1  wrong code or lockout.
- Lockout  out  1  lockout active.
- AttemptsLeft  out  4  MaxAttempts minus the failure count.

## Operation
- States and encodings: READY=0, ENTRY=1, OPEN=2, FAIL=3, LOCKOUT=4, PROG=5. Encodings 6 and 7 are illegal; the next state from either is READY.
- Reset values:
  - State=READY, Open=0, Fail=0, Lockout=0, AttemptsLeft=MaxAttempts.
  - Code register is reloaded with DefaultCode; there is no retention across reset.
  - Digit index, mismatch flag and timer are cleared.
- READY or ENTRY with Enter:
  - Compare Digit against the code nibble at the current index; OR any difference into a sticky mismatch flag; increment the index.
  - Not the last digit: go to ENTRY.
  - Last digit: if no mismatch, counting this digit, go to OPEN; otherwise go to FAIL.
  - Every digit is always collected. There is no early abort, so the failure position is not revealed.
- OPEN:
  - Open=1. On entry, the failure count clears and the timer loads OpenCycles-1.
  - Timer reaches 0: go to READY.
  - Enter with Program=1: go to PROG with index 0.
  - Enter with Program=0: relock immediately and go to READY.
- FAIL:
  - Fail=1. On entry, the failure count increments.
  - If the new count equals MaxAttempts, go to LOCKOUT on the next cycle.
  - Otherwise stay until Enter. That pulse is consumed, not treated as a digit, and the block goes to READY.
- LOCKOUT:
  - Fail=1 and Lockout=1. The timer loads LockoutCycles-1 and Enter is ignored.
  - At timer 0, go to READY and clear the failure count.
- PROG:
  - Each Enter shifts Digit into a shadow register.
  - After CodeLength digits, commit the shadow register to the code register and go to READY.
  - Program dropping to 0 before commit aborts: the code is unchanged and the block goes to READY.
  - The abort takes priority over a coincident Enter.
- Index and mismatch flag clear on every exit to READY.
- AttemptsLeft is 0 in LOCKOUT.

## Timing
- All outputs are registered Moore decodes of state.
- Open or Fail asserts on the cycle after the clock edge that samples the final Enter, so latency is 1 cycle.
- Open is high for exactly OpenCycles cycles, unless relock or PROG ends it early.
- LOCKOUT lasts exactly LockoutCycles cycles.
- FAIL to LOCKOUT costs one FAIL cycle.
- Reset has priority over every other input on the same edge.
- Enter on consecutive cycles is legal; each pulse is one digit.
- The code register changes only on the PROG commit edge. The new code applies from the next attempt.

## Structure
- Shared include lock_defs.vh holds:
  - the state encodings;
  - the CodeLength limits.
- Sub-module lock_timer: a loadable down-counter with Load, Value and Zero.
  - One instance serves both OPEN and LOCKOUT, which are mutually exclusive.
  - Width is sized for max(OpenCycles, LockoutCycles).
- The FSM, index counter, failure counter, code register and shadow register stay in lock_sequencer.

## Test plan
Parameters for all scenarios: CodeLength=4, DefaultCode=16'h1234, MaxAttempts=3, OpenCycles=8, LockoutCycles=16.
- Correct entry: Enter with digits 1,2,3,4 → State=2 and Open=1 one cycle after the 4th pulse; Open high for 8 cycles, then State=0.
- Wrong first digit: digits 9,2,3,4 → no response after the first pulse; Fail=1 and AttemptsLeft=2 only after the 4th pulse; next Enter returns State=0.
- Three consecutive failures → Lockout=1 and AttemptsLeft=0; Enter is ignored for 16 cycles; then State=0 and AttemptsLeft=3.
- Program a new code: open the lock, then Program=1 and Enter with digits 5,6,7,8 → State=0. Entering 1,2,3,4 now fails; entering 5,6,7,8 opens.
- Program abort: drop Program after 2 programming digits → State=0; 1,2,3,4 still opens.
- Reset after 2 correct digits of an attempt → State=0 with all outputs at reset values; a full 1,2,3,4 is needed to open. Reset after a new code was programmed → the code reverts to 1234.

Source files
------------

// File: rtl/lock_sequencer_pkg.sv
// Shared definitions for the combination-lock controller.
//
// Contents:
//   state_e         FSM state encodings as seen on the state_o port.
//   CODE_LEN_MIN/MAX  Legal range of digits per code.
//   code_digit()    Selects the digit at a given entry index from a code word.
//   align_code()    Moves a shifted-in shadow word into the code register layout.
package lock_sequencer_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned CODE_LEN_MIN = 1;
    localparam int unsigned CODE_LEN_MAX = 4;
    localparam int unsigned CODE_W       = DIGIT_W * CODE_LEN_MAX;
    localparam int unsigned IDX_W        = 2;
    localparam int unsigned FAIL_CNT_W   = 4;

    typedef enum logic [2:0] {
        ST_READY   = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_PROG    = 3'd5
    } state_e;

    // The first digit of a code lives in the top nibble, so digit idx is
    // found by shifting the code left idx nibbles and taking the top nibble.
    function automatic logic [DIGIT_W-1:0] code_digit(
        input logic [CODE_W-1:0] code,
        input logic [IDX_W-1:0]  idx
    );
        logic [CODE_W-1:0] shifted;
        shifted = code << (DIGIT_W * idx);
        return shifted[CODE_W-1 -: DIGIT_W];
    endfunction

    // Programming shifts digits in from the bottom; with fewer than
    // CODE_LEN_MAX digits they must be moved up to the used (upper) nibbles.
    function automatic logic [CODE_W-1:0] align_code(
        input logic [CODE_W-1:0] shadow,
        input int unsigned       code_len
    );
        return shadow << (DIGIT_W * (CODE_LEN_MAX - code_len));
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT intervals.
//
// Ports:
//   clk_i    system clock (rising edge)
//   rst_i    synchronous active-high reset, clears the count
//   load_i   load value_i into the counter this cycle
//   value_i  load value (interval length minus one)
//   zero_o   count is zero; the counter holds at zero until reloaded
module lock_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Attempt-limited, reprogrammable combination-lock controller.
// Collects CODE_LENGTH digits on enter pulses, compares them to the stored
// code, drives timed open/fail indication and a lockout after MAX_ATTEMPTS
// consecutive failures. While open, a new code may be programmed.
//
// Ports:
//   clk_i            system clock (rising edge)
//   rst_i            synchronous active-high reset
//   enter_i          single-cycle digit strobe
//   digit_i          digit sampled on enter_i
//   program_i        level request to program a new code (while open)
//   state_o          current state encoding (see state_e)
//   open_o           lock open
//   fail_o           wrong code or lockout
//   lockout_o        lockout active
//   attempts_left_o  MAX_ATTEMPTS minus consecutive failures (0 in lockout)
module lock_sequencer
    import lock_sequencer_pkg::*;
#(
    parameter int unsigned       CLOCK_FREQ     = 50_000_000,
    parameter int unsigned       CODE_LENGTH    = 4,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned       MAX_ATTEMPTS   = 3,
    parameter int unsigned       OPEN_CYCLES    = CLOCK_FREQ * 5,
    parameter int unsigned       LOCKOUT_CYCLES = CLOCK_FREQ * 30
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enter_i,
    input  logic [3:0]   digit_i,
    input  logic         program_i,
    output logic [2:0]   state_o,
    output logic         open_o,
    output logic         fail_o,
    output logic         lockout_o,
    output logic [3:0]   attempts_left_o
);

    localparam int unsigned TIMER_MAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0]    OPEN_LOAD    = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0]    LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(CODE_LENGTH - 1);
    localparam logic [FAIL_CNT_W-1:0] MAX_FAILS    = FAIL_CNT_W'(MAX_ATTEMPTS);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  mismatch_q, mismatch_d;
    logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [CODE_W-1:0]     shadow_q, shadow_d;
    logic                  open_q, fail_q, lockout_q;
    logic [3:0]            attempts_q;

    logic                  digit_miss;
    logic                  timer_load;
    logic [TIMER_W-1:0]    timer_value;
    logic                  timer_zero;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mismatch_d = mismatch_q;
        fail_cnt_d = fail_cnt_q;
        code_d     = code_q;
        shadow_d   = shadow_q;
        digit_miss = (digit_i != code_digit(code_q, idx_q));

        case (state_q)
            ST_READY, ST_ENTRY: begin
                // All digits are always collected; only the final digit
                // decides, so the position of a wrong digit stays hidden.
                if (enter_i) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        mismatch_d = 1'b0;
                        if (mismatch_q || digit_miss) begin
                            state_d    = ST_FAIL;
                            fail_cnt_d = fail_cnt_q + 1'b1;
                        end else begin
                            state_d    = ST_OPEN;
                            fail_cnt_d = '0;
                        end
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        mismatch_d = mismatch_q | digit_miss;
                        state_d    = ST_ENTRY;
                    end
                end
            end
            ST_OPEN: begin
                if (enter_i) begin
                    if (program_i) begin
                        state_d  = ST_PROG;
                        idx_d    = '0;
                        shadow_d = '0;
                    end else begin
                        state_d = ST_READY;
                    end
                end else if (timer_zero) begin
                    state_d = ST_READY;
                end
            end
            ST_FAIL: begin
                // The count was bumped on entry, so the limit is already visible here.
                if (fail_cnt_q == MAX_FAILS) begin
                    state_d = ST_LOCKOUT;
                end else if (enter_i) begin
                    state_d = ST_READY;
                end
            end
            ST_LOCKOUT: begin
                if (timer_zero) begin
                    state_d    = ST_READY;
                    fail_cnt_d = '0;
                end
            end
            ST_PROG: begin
                // Dropping program_i wins over a coincident enter_i.
                if (!program_i) begin
                    state_d = ST_READY;
                end else if (enter_i) begin
                    shadow_d = {shadow_q[CODE_W-DIGIT_W-1:0], digit_i};
                    if (idx_q == LAST_IDX) begin
                        code_d  = align_code(shadow_d, CODE_LENGTH);
                        state_d = ST_READY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_READY;
        endcase

        if (state_d == ST_READY && state_q != ST_READY) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
        end
    end

    // One timer serves both timed states; it is loaded on the entry edge.
    assign timer_load  = (state_d != state_q) && (state_d == ST_OPEN || state_d == ST_LOCKOUT);
    assign timer_value = (state_d == ST_LOCKOUT) ? LOCKOUT_LOAD : OPEN_LOAD;

    lock_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (timer_load),
        .value_i (timer_value),
        .zero_o  (timer_zero)
    );

    // Outputs are decoded from the next state and registered, so they line
    // up with state_q and appear one cycle after the deciding enter pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_READY;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            fail_cnt_q <= '0;
            // NOTE: the code register is a small register bank, not a RAM,
            // so it is reset to a known code; nothing survives a reset.
            code_q     <= DEFAULT_CODE;
            shadow_q   <= '0;
            open_q     <= 1'b0;
            fail_q     <= 1'b0;
            lockout_q  <= 1'b0;
            attempts_q <= MAX_FAILS;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mismatch_q <= mismatch_d;
            fail_cnt_q <= fail_cnt_d;
            code_q     <= code_d;
            shadow_q   <= shadow_d;
            open_q     <= (state_d == ST_OPEN);
            fail_q     <= (state_d == ST_FAIL) || (state_d == ST_LOCKOUT);
            lockout_q  <= (state_d == ST_LOCKOUT);
            attempts_q <= (state_d == ST_LOCKOUT) ? 4'd0 : (MAX_FAILS - fail_cnt_d);
        end
    end

    assign state_o         = state_q;
    assign open_o          = open_q;
    assign fail_o          = fail_q;
    assign lockout_o       = lockout_q;
    assign attempts_left_o = attempts_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Directed testbench for lock_sequencer with hand-computed expectations.
// Parameters: CODE_LENGTH=4, DEFAULT_CODE=16'h1234, MAX_ATTEMPTS=3,
// OPEN_CYCLES=8, LOCKOUT_CYCLES=16. Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_lock_sequencer;

    localparam logic [2:0] S_READY   = 3'd0;
    localparam logic [2:0] S_ENTRY   = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_LOCKOUT = 3'd4;
    localparam logic [2:0] S_PROG    = 3'd5;

    logic       clk = 1'b0;
    logic       rst;
    logic       enter;
    logic [3:0] digit;
    logic       program_req;
    logic [2:0] state;
    logic       open_w;
    logic       fail_w;
    logic       lockout_w;
    logic [3:0] attempts;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    lock_sequencer #(
        .CLOCK_FREQ     (50_000_000),
        .CODE_LENGTH    (4),
        .DEFAULT_CODE   (16'h1234),
        .MAX_ATTEMPTS   (3),
        .OPEN_CYCLES    (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enter_i         (enter),
        .digit_i         (digit),
        .program_i       (program_req),
        .state_o         (state),
        .open_o          (open_w),
        .fail_o          (fail_w),
        .lockout_o       (lockout_w),
        .attempts_left_o (attempts)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One enter pulse covering exactly one rising edge; returns on the
    // falling edge just after that edge, where the response is visible.
    task automatic press(input logic [3:0] d);
        @(negedge clk);
        enter = 1'b1;
        digit = d;
        @(negedge clk);
        enter = 1'b0;
    endtask

    task automatic press_code(input logic [15:0] code);
        logic [15:0] c;
        c = code;
        for (int i = 0; i < 4; i++) begin
            press(c[15:12]);
            c = c << 4;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},    16'(state),     16'(S_READY));
        check({tag, "_open"},     16'(open_w),    16'd0);
        check({tag, "_fail"},     16'(fail_w),    16'd0);
        check({tag, "_lockout"},  16'(lockout_w), 16'd0);
        check({tag, "_attempts"}, 16'(attempts),  16'd3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        enter       = 1'b0;
        digit       = 4'd0;
        program_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset holds even with a coincident enter pulse.
        enter = 1'b1;
        digit = 4'd1;
        @(negedge clk);
        check_reset_values("reset");
        enter = 1'b0;
        rst   = 1'b0;

        // Correct entry: open one cycle after the 4th digit, for 8 cycles.
        press(4'd1);
        press(4'd2);
        press(4'd3);
        check("entry_partial_state", 16'(state),  16'(S_ENTRY));
        check("entry_partial_open",  16'(open_w), 16'd0);
        press(4'd4);
        check("open_state", 16'(state),  16'(S_OPEN));
        check("open_flag",  16'(open_w), 16'd1);
        check("open_fail",  16'(fail_w), 16'd0);
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            check("open_hold", 16'(open_w), 16'd1);
        end
        @(negedge clk);
        check("open_expire_state", 16'(state),  16'(S_READY));
        check("open_expire_flag",  16'(open_w), 16'd0);

        // Wrong first digit: nothing until the 4th pulse.
        press(4'd9);
        check("wrong_first_state", 16'(state),  16'(S_ENTRY));
        check("wrong_first_fail",  16'(fail_w), 16'd0);
        press(4'd2);
        press(4'd3);
        check("wrong_mid_fail", 16'(fail_w), 16'd0);
        press(4'd4);
        check("wrong_state",    16'(state),    16'(S_FAIL));
        check("wrong_fail",     16'(fail_w),   16'd1);
        check("wrong_attempts", 16'(attempts), 16'd2);
        @(negedge clk);
        check("wrong_hold", 16'(state), 16'(S_FAIL));
        press(4'd0);
        check("fail_ack_state",    16'(state),    16'(S_READY));
        check("fail_ack_fail",     16'(fail_w),   16'd0);
        check("fail_ack_attempts", 16'(attempts), 16'd2);

        // Second and third failures lead to lockout.
        press_code(16'h1235);
        check("fail2_attempts", 16'(attempts), 16'd1);
        press(4'd0);
        press_code(16'h0000);
        check("fail3_state",    16'(state),    16'(S_FAIL));
        check("fail3_attempts", 16'(attempts), 16'd0);
        check("fail3_lockout",  16'(lockout_w), 16'd0);
        @(negedge clk);
        check("lockout_state",    16'(state),     16'(S_LOCKOUT));
        check("lockout_flag",     16'(lockout_w), 16'd1);
        check("lockout_fail",     16'(fail_w),    16'd1);
        check("lockout_attempts", 16'(attempts),  16'd0);
        enter = 1'b1;
        digit = 4'd1;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            check("lockout_hold", 16'(lockout_w), 16'd1);
        end
        enter = 1'b0;
        @(negedge clk);
        check_reset_values("lockout_end");

        // Program abort after 2 digits, abort coinciding with enter.
        press_code(16'h1234);
        check("abort_open", 16'(state), 16'(S_OPEN));
        program_req = 1'b1;
        press(4'd0);
        check("prog_enter_state", 16'(state),  16'(S_PROG));
        check("prog_enter_open",  16'(open_w), 16'd0);
        press(4'd5);
        press(4'd6);
        check("prog_mid_state", 16'(state), 16'(S_PROG));
        @(negedge clk);
        program_req = 1'b0;
        enter       = 1'b1;
        digit       = 4'd7;
        @(negedge clk);
        enter = 1'b0;
        check("abort_state", 16'(state), 16'(S_READY));
        press_code(16'h1234);
        check("abort_code_kept", 16'(open_w), 16'd1);

        // Program 5678 from the open state.
        program_req = 1'b1;
        press(4'd0);
        press(4'd5);
        press(4'd6);
        press(4'd7);
        check("prog_3_state", 16'(state), 16'(S_PROG));
        press(4'd8);
        check("prog_commit_state", 16'(state), 16'(S_READY));
        program_req = 1'b0;
        press_code(16'h1234);
        check("old_code_state",    16'(state),    16'(S_FAIL));
        check("old_code_attempts", 16'(attempts), 16'd2);
        press(4'd0);
        press_code(16'h5678);
        check("new_code_state",    16'(state),    16'(S_OPEN));
        check("new_code_attempts", 16'(attempts), 16'd3);
        press(4'd0);
        check("relock_state", 16'(state),  16'(S_READY));
        check("relock_open",  16'(open_w), 16'd0);

        // Reset mid-attempt clears the index and restores the default code.
        press(4'd5);
        press(4'd6);
        check("pre_reset_state", 16'(state), 16'(S_ENTRY));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("mid_reset");
        press(4'd7);
        press(4'd8);
        check("idx_cleared_state", 16'(state),  16'(S_ENTRY));
        check("idx_cleared_open",  16'(open_w), 16'd0);
        press(4'd3);
        press(4'd4);
        check("post_reset_partial", 16'(state), 16'(S_FAIL));
        press(4'd0);
        press_code(16'h5678);
        check("programmed_code_gone", 16'(state),    16'(S_FAIL));
        check("post_reset_attempts",  16'(attempts), 16'd1);
        press(4'd0);
        press_code(16'h1234);
        check("code_reverted", 16'(open_w), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
